// File: rtl/particle_pair_dispatcher_if.sv
// Lane bundle between the pair dispatcher (master) and the filter bank (slave):
// per-lane pair valid, particle IDs, coordinates and per-lane back-pressure.
interface particle_pair_dispatcher_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_FILTER        = 4,
  parameter int PARTICLE_ID_WIDTH = 20
);
  logic [NUM_FILTER-1:0]                   back_pressure;
  logic [NUM_FILTER-1:0]                   input_valid;
  logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0] ref_particle_id;
  logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0] neighbor_particle_id;
  logic [NUM_FILTER*DATA_WIDTH-1:0]        refx, refy, refz;
  logic [NUM_FILTER*DATA_WIDTH-1:0]        neighborx, neighbory, neighborz;

  modport master (
    input  back_pressure,
    output input_valid, ref_particle_id, neighbor_particle_id,
    output refx, refy, refz, neighborx, neighbory, neighborz
  );

  modport slave (
    output back_pressure,
    input  input_valid, ref_particle_id, neighbor_particle_id,
    input  refx, refy, refz, neighborx, neighbory, neighborz
  );
endinterface

// File: rtl/particle_pair_dispatcher.sv
// Streams reference/neighbor particle pairs of one cell pair into the filter lanes.
// Optional feature macro: SKIP_SELF_PAIR_EN (same-cell jobs emit each pair once, no self pair).
//
// state    | meaning
// IDLE     | wait for start, latch job parameters
// LOAD_REF | read up to NUM_FILTER reference particles into the lanes
// STREAM   | broadcast neighbor particles, one per cycle, stalled by back-pressure
// DRAIN    | let the two in-flight pairs leave, then advance ref_base
// FINISH   | one-cycle done pulse
module particle_pair_dispatcher #(
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_FILTER        = 4,
  parameter int PARTICLE_ID_WIDTH = 20,
  parameter int CELL_ID_WIDTH     = 12,
  parameter int ADDR_WIDTH        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CELL_ID_WIDTH-1:0] home_cell_id,
  input  logic [CELL_ID_WIDTH-1:0] neighbor_cell_id,
  input  logic [ADDR_WIDTH-1:0]    home_particle_num,
  input  logic [ADDR_WIDTH-1:0]    neighbor_particle_num,
  output logic                     ref_rd_en,
  output logic [ADDR_WIDTH-1:0]    ref_rd_addr,
  input  logic [3*DATA_WIDTH-1:0]  ref_rd_data,
  output logic                     nb_rd_en,
  output logic [ADDR_WIDTH-1:0]    nb_rd_addr,
  input  logic [3*DATA_WIDTH-1:0]  nb_rd_data,
  output logic                     busy,
  output logic                     done,
  particle_pair_dispatcher_if.master pair
);

  localparam int IW = ADDR_WIDTH + 1;
  localparam int KW = $clog2(NUM_FILTER + 1);
  localparam int DW = DATA_WIDTH;
  localparam int PW = PARTICLE_ID_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD_REF, STREAM, DRAIN, FINISH} state_t;

  state_t state, state_nxt;

  logic [CELL_ID_WIDTH-1:0] home_cell, nb_cell;
  logic [IW-1:0]            home_num, nb_num, ref_base, nb_idx;
  logic [IW-1:0]            ref_idx, ref_base_nxt;
  logic [ADDR_WIDTH-1:0]    nb_pend_idx;
  logic [KW-1:0]            ref_k, ref_pend_lane;
  logic                     ref_pend, nb_pend, drain_cnt;
`ifdef SKIP_SELF_PAIR_EN
  logic                     same_cell;
`endif

  logic [IW-1:0]            lane_idx [NUM_FILTER];
  logic [NUM_FILTER-1:0]    lane_active, skip, lane_mask;
  logic [DW-1:0]            held_x [NUM_FILTER];
  logic [DW-1:0]            held_y [NUM_FILTER];
  logic [DW-1:0]            held_z [NUM_FILTER];

  logic [NUM_FILTER-1:0]    valid_q;
  logic [NUM_FILTER*PW-1:0] ref_id_q, nb_id_q;
  logic [NUM_FILTER*DW-1:0] rx_q, ry_q, rz_q, nx_q, ny_q, nz_q;

  // Index math is one bit wider than the address so ref_base past the end never aliases.
  assign ref_idx      = ref_base + IW'(ref_k);
  assign ref_base_nxt = ref_base + IW'(NUM_FILTER);

  always_comb begin
    for (int i = 0; i < NUM_FILTER; i++) begin
      lane_idx[i]    = ref_base + IW'(i);
      lane_active[i] = lane_idx[i] < home_num;
    end
  end

  always_comb begin
    skip = '0;
`ifdef SKIP_SELF_PAIR_EN
    for (int i = 0; i < NUM_FILTER; i++)
      skip[i] = same_cell && ({1'b0, nb_pend_idx} <= lane_idx[i]);
`endif
  end

  assign lane_mask = lane_active & ~skip;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (start)
          state_nxt = (home_particle_num == '0 || neighbor_particle_num == '0) ? FINISH : LOAD_REF;
      LOAD_REF:
        if (ref_k == KW'(NUM_FILTER)) state_nxt = STREAM;
      STREAM:
        if (nb_rd_en && (nb_idx + IW'(1) == nb_num)) state_nxt = DRAIN;
      DRAIN:
        if (drain_cnt) state_nxt = (ref_base_nxt < home_num) ? LOAD_REF : FINISH;
      FINISH:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ref_rd_en = 1'b0;
    nb_rd_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      LOAD_REF: begin
        busy      = 1'b1;
        ref_rd_en = (ref_k < KW'(NUM_FILTER)) && (ref_idx < home_num);
      end
      STREAM: begin
        busy     = 1'b1;
        nb_rd_en = (pair.back_pressure == '0) && (nb_idx < nb_num);
      end
      DRAIN:   busy = 1'b1;
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  assign ref_rd_addr = ref_rd_en ? ref_idx[ADDR_WIDTH-1:0] : '0;
  assign nb_rd_addr  = nb_rd_en  ? nb_idx[ADDR_WIDTH-1:0]  : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      home_cell     <= '0;
      nb_cell       <= '0;
      home_num      <= '0;
      nb_num        <= '0;
      ref_base      <= '0;
      nb_idx        <= '0;
      nb_pend_idx   <= '0;
      ref_k         <= '0;
      ref_pend_lane <= '0;
      ref_pend      <= 1'b0;
      nb_pend       <= 1'b0;
      drain_cnt     <= 1'b0;
`ifdef SKIP_SELF_PAIR_EN
      same_cell     <= 1'b0;
`endif
    end else begin
      ref_pend      <= ref_rd_en;
      ref_pend_lane <= ref_k;
      nb_pend       <= nb_rd_en;
      nb_pend_idx   <= nb_idx[ADDR_WIDTH-1:0];
      case (state)
        IDLE:
          if (start) begin
            home_cell <= home_cell_id;
            nb_cell   <= neighbor_cell_id;
            home_num  <= {1'b0, home_particle_num};
            nb_num    <= {1'b0, neighbor_particle_num};
            ref_base  <= '0;
            ref_k     <= '0;
            nb_idx    <= '0;
            drain_cnt <= 1'b0;
`ifdef SKIP_SELF_PAIR_EN
            same_cell <= (home_cell_id == neighbor_cell_id);
`endif
          end
        LOAD_REF: begin
          ref_k     <= ref_k + KW'(1);
          nb_idx    <= '0;
          drain_cnt <= 1'b0;
        end
        STREAM:
          if (nb_rd_en) nb_idx <= nb_idx + IW'(1);
        DRAIN: begin
          drain_cnt <= ~drain_cnt;
          if (drain_cnt) begin
            ref_base <= ref_base_nxt;
            ref_k    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FILTER; i++) begin
      if (ref_pend && ref_pend_lane == KW'(i)) begin
        held_x[i] <= ref_rd_data[DW-1:0];
        held_y[i] <= ref_rd_data[2*DW-1:DW];
        held_z[i] <= ref_rd_data[3*DW-1:2*DW];
      end
    end
  end

  // Pair outputs are registered off the neighbor read data: issue at t, valid at t+2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      ref_id_q <= '0;
      nb_id_q  <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      rz_q     <= '0;
      nx_q     <= '0;
      ny_q     <= '0;
      nz_q     <= '0;
    end else begin
      valid_q <= nb_pend ? lane_mask : '0;
      if (nb_pend) begin
        for (int i = 0; i < NUM_FILTER; i++) begin
          ref_id_q[i*PW +: PW] <= {home_cell, lane_idx[i][ADDR_WIDTH-1:0]};
          nb_id_q[i*PW +: PW]  <= {nb_cell, nb_pend_idx};
          rx_q[i*DW +: DW]     <= held_x[i];
          ry_q[i*DW +: DW]     <= held_y[i];
          rz_q[i*DW +: DW]     <= held_z[i];
          nx_q[i*DW +: DW]     <= nb_rd_data[DW-1:0];
          ny_q[i*DW +: DW]     <= nb_rd_data[2*DW-1:DW];
          nz_q[i*DW +: DW]     <= nb_rd_data[3*DW-1:2*DW];
        end
      end
    end
  end

  assign pair.input_valid          = valid_q;
  assign pair.ref_particle_id      = ref_id_q;
  assign pair.neighbor_particle_id = nb_id_q;
  assign pair.refx                 = rx_q;
  assign pair.refy                 = ry_q;
  assign pair.refz                 = rz_q;
  assign pair.neighborx            = nx_q;
  assign pair.neighbory            = ny_q;
  assign pair.neighborz            = nz_q;

endmodule

// File: tb/tb_particle_pair_dispatcher.sv
// Bench for particle_pair_dispatcher: memory models, pair scoreboard, job vector table.
module tb_particle_pair_dispatcher;
  localparam int DW = 32;
  localparam int NF = 4;
  localparam int PW = 20;
  localparam int CW = 12;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] home_cell_id, neighbor_cell_id;
  logic [AW-1:0] home_particle_num, neighbor_particle_num;
  logic          ref_rd_en, nb_rd_en;
  logic [AW-1:0] ref_rd_addr, nb_rd_addr;
  logic [3*DW-1:0] ref_rd_data, nb_rd_data;
  logic          busy, done;

  particle_pair_dispatcher_if #(.DATA_WIDTH(DW), .NUM_FILTER(NF), .PARTICLE_ID_WIDTH(PW)) pif ();

  particle_pair_dispatcher #(
    .DATA_WIDTH(DW), .NUM_FILTER(NF), .PARTICLE_ID_WIDTH(PW),
    .CELL_ID_WIDTH(CW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .home_cell_id(home_cell_id), .neighbor_cell_id(neighbor_cell_id),
    .home_particle_num(home_particle_num), .neighbor_particle_num(neighbor_particle_num),
    .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
    .nb_rd_en(nb_rd_en), .nb_rd_addr(nb_rd_addr), .nb_rd_data(nb_rd_data),
    .busy(busy), .done(done), .pair(pif.master)
  );

  always #5 clk = ~clk;

  function automatic logic [3*DW-1:0] ref_coord(input logic [CW-1:0] c, input logic [AW-1:0] a);
    return {8'h3c, c, 4'h2, a, 8'h3b, c, 4'h1, a, 8'h3a, c, 4'h0, a};
  endfunction

  function automatic logic [3*DW-1:0] nb_coord(input logic [CW-1:0] c, input logic [AW-1:0] a);
    return {8'h4c, c, 4'h6, a, 8'h4b, c, 4'h5, a, 8'h4a, c, 4'h4, a};
  endfunction

  always @(posedge clk) begin
    if (ref_rd_en) ref_rd_data <= ref_coord(home_cell_id, ref_rd_addr);
    if (nb_rd_en)  nb_rd_data  <= nb_coord(neighbor_cell_id, nb_rd_addr);
  end

  typedef struct {
    logic [NF-1:0] mask;
    int            base;
    int            j;
    logic [CW-1:0] hc, nc;
  } beat_t;

  typedef struct {
    logic [CW-1:0] hc, nc;
    logic [AW-1:0] h, n;
    int            pairs;
    int            cyc;
  } vec_t;

  beat_t sb[$];
  vec_t  vt[6];
  int total = 0, bad = 0;
  int cyc, pairs, beats, ref_reads, nb_reads, done_cnt, done_cyc, busy_err, idle_err;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push_job(input logic [CW-1:0] hc, nc, input int h, n);
    for (int b = 0; b < h; b += NF)
      for (int j = 0; j < n; j++) begin
        beat_t bt;
        bt.base = b; bt.j = j; bt.hc = hc; bt.nc = nc; bt.mask = '0;
        for (int i = 0; i < NF; i++) begin
          bt.mask[i] = (b + i) < h;
`ifdef SKIP_SELF_PAIR_EN
          if (hc == nc && j <= b + i) bt.mask[i] = 1'b0;
`endif
        end
        if (bt.mask != '0) sb.push_back(bt);
      end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst) return;
    if (ref_rd_en) ref_reads++;
    if (nb_rd_en)  nb_reads++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (pif.input_valid != '0) begin
      pairs += $countones(pif.input_valid);
      beats++;
      if (sb.size() == 0) chk("unexpected_beat", 128'(pif.input_valid), 128'(0));
      else begin
        beat_t bt;
        bt = sb.pop_front();
        chk("valid_mask", 128'(pif.input_valid), 128'(bt.mask));
        for (int i = 0; i < NF; i++) if (bt.mask[i]) begin
          logic [AW-1:0] ri, nj;
          ri = AW'(bt.base + i);
          nj = AW'(bt.j);
          chk("ref_id", 128'(pif.ref_particle_id[i*PW +: PW]), 128'({bt.hc, ri}));
          chk("nb_id", 128'(pif.neighbor_particle_id[i*PW +: PW]), 128'({bt.nc, nj}));
          chk("ref_xyz", 128'({pif.refz[i*DW +: DW], pif.refy[i*DW +: DW], pif.refx[i*DW +: DW]}),
              128'(ref_coord(bt.hc, ri)));
          chk("nb_xyz", 128'({pif.neighborz[i*DW +: DW], pif.neighbory[i*DW +: DW], pif.neighborx[i*DW +: DW]}),
              128'(nb_coord(bt.nc, nj)));
        end
      end
    end
  endtask

  task automatic begin_job(input logic [CW-1:0] hc, nc, input logic [AW-1:0] h, n);
    home_cell_id = hc; neighbor_cell_id = nc;
    home_particle_num = h; neighbor_particle_num = n;
    sb.delete();
    push_job(hc, nc, int'(h), int'(n));
    cyc = 0; pairs = 0; beats = 0; ref_reads = 0; nb_reads = 0;
    done_cnt = 0; done_cyc = -1; busy_err = 0; idle_err = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    while (done_cnt == 0 && cyc < 600) begin
      if (!busy) busy_err++;
      tick();
    end
  endtask

  task automatic end_job(input string nm, input int h, n, exp_pairs, exp_cyc);
    int er, en;
    er = (n == 0) ? 0 : h;
    en = (h == 0) ? 0 : ((h + NF - 1) / NF) * n;
    chk({nm, "_done_seen"}, 128'(done_cnt), 128'(1));
    chk({nm, "_done_cycle"}, 128'(done_cyc), 128'(exp_cyc));
    chk({nm, "_busy_at_done"}, 128'(busy), 128'(0));
    // a start pulse coincident with done must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (busy || ref_rd_en || done) idle_err++;
      tick();
    end
    chk({nm, "_busy_gap"}, 128'(busy_err), 128'(0));
    chk({nm, "_idle_after_done"}, 128'(idle_err), 128'(0));
    chk({nm, "_done_pulses"}, 128'(done_cnt), 128'(1));
    chk({nm, "_pairs"}, 128'(pairs), 128'(exp_pairs));
    chk({nm, "_sb_empty"}, 128'(sb.size()), 128'(0));
    chk({nm, "_ref_reads"}, 128'(ref_reads), 128'(er));
    chk({nm, "_nb_reads"}, 128'(nb_reads), 128'(en));
  endtask

  initial begin
    int bp_beats, bp_reads, b0;

    vt[0] = '{12'h011, 12'h022, 8'd4, 8'd3, 12, 11};
    vt[1] = '{12'h033, 12'h044, 8'd6, 8'd2, 12, 19};
    vt[2] = '{12'h055, 12'h066, 8'd0, 8'd3, 0, 1};
    vt[3] = '{12'h077, 12'h088, 8'd5, 8'd0, 0, 1};
    vt[4] = '{12'h099, 12'h09a, 8'd9, 8'd1, 9, 25};
`ifdef SKIP_SELF_PAIR_EN
    vt[5] = '{12'h0aa, 12'h0aa, 8'd4, 8'd4, 6, 12};
`else
    vt[5] = '{12'h0aa, 12'h0aa, 8'd4, 8'd4, 16, 12};
`endif

    rst = 1'b0; start = 1'b0; pif.back_pressure = '0;
    home_cell_id = '0; neighbor_cell_id = '0;
    home_particle_num = '0; neighbor_particle_num = '0;
    cyc = 0; pairs = 0; beats = 0; ref_reads = 0; nb_reads = 0; done_cnt = 0;
    tick(); tick();
    chk("rst_valid", 128'(pif.input_valid), 128'(0));
    chk("rst_ids", 128'({pif.ref_particle_id, pif.neighbor_particle_id}), 128'(0));
    chk("rst_coords", 128'({pif.refx, pif.neighborz}), 128'(0));
    chk("rst_ctrl", 128'({busy, done, ref_rd_en, nb_rd_en, ref_rd_addr, nb_rd_addr}), 128'(0));
    rst = 1'b1;
    tick();
    chk("idle_after_rst", 128'({busy, done, ref_rd_en, nb_rd_en}), 128'(0));

    for (int v = 0; v < 6; v++) begin
      begin_job(vt[v].hc, vt[v].nc, vt[v].h, vt[v].n);
      wait_done();
      end_job($sformatf("vec%0d", v), int'(vt[v].h), int'(vt[v].n), vt[v].pairs, vt[v].cyc);
    end

    // back-pressure on one lane mid-stream stalls every lane
    begin_job(12'h100, 12'h200, 8'd4, 8'd8);
    while (beats == 0 && cyc < 100) tick();
    chk("bp_first_beat_cycle", 128'(cyc), 128'(8));
    pif.back_pressure = 4'b0100;
    b0 = beats; bp_reads = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (nb_rd_en) bp_reads++;
    end
    bp_beats = beats - b0;
    pif.back_pressure = '0;
    chk("bp_no_issue", 128'(bp_reads), 128'(0));
    chk("bp_slack_le2", 128'(bp_beats <= 2), 128'(1));
    wait_done();
    end_job("bp", 4, 8, 32, 21);

    // reset during STREAM aborts without done
    begin_job(12'h300, 12'h301, 8'd4, 8'd8);
    while (beats < 2 && cyc < 100) tick();
    rst = 1'b0;
    #1;
    chk("abort_valid", 128'(pif.input_valid), 128'(0));
    chk("abort_ctrl", 128'({busy, done, ref_rd_en, nb_rd_en}), 128'(0));
    chk("abort_data", 128'({pif.ref_particle_id, pif.neighborx}), 128'(0));
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("abort_no_done", 128'(done_cnt), 128'(0));
    chk("abort_idle", 128'({busy, nb_rd_en, pif.input_valid}), 128'(0));
    begin_job(12'h300, 12'h301, 8'd4, 8'd3);
    wait_done();
    end_job("post_rst", 4, 3, 12, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
